// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU bias-load path.
package npu_pkg;

    // Bias loader control states
    typedef enum logic [1:0] {
        BL_IDLE     = 2'd0,
        BL_CLEAR    = 2'd1,
        BL_STREAM   = 2'd2,
        BL_WAIT_ACK = 2'd3
    } bias_ldr_state_e;

    // Largest bias table the loader accepts; channel counts fit in 9 bits
    localparam int unsigned BIAS_LDR_MAX_CH = 511;
    localparam int unsigned BIAS_LDR_CH_W   = 9;

    // Number of memory words needed to hold n biases packed bpw to a word
    function automatic logic [BIAS_LDR_CH_W-1:0] bias_ldr_words(
        input logic [BIAS_LDR_CH_W-1:0] n,
        input int unsigned              bpw
    );
        int unsigned w;
        w = (32'(n) + bpw - 32'd1) / bpw;
        return w[BIAS_LDR_CH_W-1:0];
    endfunction

endpackage

// File: rtl/bias_word_fifo.sv
// Small synchronous FIFO holding returned memory words until they are unpacked.
// Head data is read straight from storage so the unpacker sees it the cycle
// after the push.
module bias_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer increment with wrap for any depth
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Guarded push/pop and next-state for storage, pointers and count
    always_comb begin
        push_ok_s = push && (count_q != CNT_FULL);
        pop_ok_s  = pop && (count_q != '0);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bias_stream_loader.sv
// Fetches a packed bias table from memory and streams it to the bias-add unit:
// one clear pulse, then one bias per cycle, then waits for the consumer ack.
// Reads are credit limited so returned words always fit in the word FIFO.
module bias_stream_loader
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MEM_WIDTH       = 64,
    parameter int unsigned BIAS_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ACK_TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [8:0]             num_channels,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [MEM_WIDTH-1:0]   mem_rdata,
    output logic                   load_bias,
    output logic                   bias_valid,
    output logic [BIAS_WIDTH-1:0]  bias_out,
    input  logic                   bias_loaded
);

    localparam int unsigned BPW    = MEM_WIDTH / BIAS_WIDTH;
    localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned OCC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TMR_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(MEM_WIDTH / 8);
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(BPW - 1);
    localparam logic [OCC_W-1:0]      OCC_MAX   = OCC_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE     = 2'(BL_IDLE);
    localparam logic [1:0] S_CLEAR    = 2'(BL_CLEAR);
    localparam logic [1:0] S_STREAM   = 2'(BL_STREAM);
    localparam logic [1:0] S_WAIT_ACK = 2'(BL_WAIT_ACK);

    logic [1:0]            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  load_bias_q, load_bias_d;
    logic                  bias_valid_q, bias_valid_d;
    logic [BIAS_WIDTH-1:0] bias_out_q, bias_out_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [8:0]            beats_left_q, beats_left_d;
    logic [8:0]            words_left_q, words_left_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [TMR_W-1:0]      ack_timer_q, ack_timer_d;
    // reads granted but not yet returned
    logic [OCC_W-1:0]      outstanding_q, outstanding_d;
    // reads granted and not yet fully unpacked (outstanding + FIFO words)
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic                  gnt_fire_s;
    logic                  push_s;
    logic                  emit_s;
    logic                  pop_s;
    logic [MEM_WIDTH-1:0]  fifo_head_s;
    logic [OCC_W-1:0]      fifo_count_s;
    logic [BIAS_WIDTH-1:0] lanes_s [BPW];

    bias_word_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (MEM_WIDTH)
    ) u_word_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (mem_rdata),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s)
    );

    for (genvar g = 0; g < int'(BPW); g++) begin : g_lane
        assign lanes_s[g] = fifo_head_s[g*BIAS_WIDTH +: BIAS_WIDTH];
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign load_bias  = load_bias_q;
    assign bias_valid = bias_valid_q;
    assign bias_out   = bias_out_q;

    // Handshake events: grant, accepted return data, lane emission and word pop
    always_comb begin
        gnt_fire_s = mem_req_q && mem_gnt;
        // Returns with nothing outstanding belong to requests cut off by reset
        push_s     = mem_rvalid && (outstanding_q != '0) && (state_q != S_IDLE);
        emit_s     = (state_q == S_STREAM) && (fifo_count_s != '0) && (beats_left_q != 9'd0);
        // A word is done after its last lane, or early when the table ends mid-word
        pop_s      = emit_s && ((lane_q == LAST_LANE) || (beats_left_q == 9'd1));
    end

    // FSM, request/credit bookkeeping and registered output values
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        load_bias_d   = 1'b0;
        bias_valid_d  = 1'b0;
        bias_out_d    = bias_out_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        beats_left_d  = beats_left_q;
        words_left_d  = words_left_q;
        lane_d        = lane_q;
        ack_timer_d   = ack_timer_q;
        outstanding_d = outstanding_q;
        occ_d         = occ_q;

        if (gnt_fire_s && !push_s) begin
            outstanding_d = outstanding_q + OCC_W'(1);
        end else if (!gnt_fire_s && push_s) begin
            outstanding_d = outstanding_q - OCC_W'(1);
        end else begin
            outstanding_d = outstanding_q;
        end

        if (gnt_fire_s && !pop_s) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!gnt_fire_s && pop_s) begin
            occ_d = occ_q - OCC_W'(1);
        end else begin
            occ_d = occ_q;
        end

        // Address only advances once the current request is accepted
        if (gnt_fire_s) begin
            mem_addr_d   = mem_addr_q + ADDR_STEP;
            words_left_d = words_left_q - 9'd1;
        end else begin
            mem_addr_d   = mem_addr_q;
            words_left_d = words_left_q;
        end

        if (emit_s) begin
            bias_valid_d = 1'b1;
            bias_out_d   = lanes_s[lane_q];
            beats_left_d = beats_left_q - 9'd1;
            if (pop_s) begin
                lane_d = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end else begin
            bias_out_d = bias_out_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_channels == 9'd0) begin
                        error_d = 1'b1;
                    end else begin
                        state_d      = S_CLEAR;
                        busy_d       = 1'b1;
                        load_bias_d  = 1'b1;
                        mem_addr_d   = base_addr;
                        beats_left_d = num_channels;
                        words_left_d = bias_ldr_words(num_channels, BPW);
                        lane_d       = '0;
                        ack_timer_d  = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (emit_s && (beats_left_q == 9'd1)) begin
                    state_d     = S_WAIT_ACK;
                    ack_timer_d = '0;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_WAIT_ACK: begin
                if (bias_loaded) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (ack_timer_q == TMR_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ack_timer_d = ack_timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // An unaccepted request is held; a new one needs work left and a free credit
        if (mem_req_q && !mem_gnt) begin
            mem_req_d = (state_d == S_STREAM);
        end else begin
            mem_req_d = (state_d == S_STREAM) && (words_left_d != 9'd0) && (occ_d < OCC_MAX);
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            load_bias_q   <= 1'b0;
            bias_valid_q  <= 1'b0;
            bias_out_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            beats_left_q  <= 9'd0;
            words_left_q  <= 9'd0;
            lane_q        <= '0;
            ack_timer_q   <= '0;
            outstanding_q <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            load_bias_q   <= load_bias_d;
            bias_valid_q  <= bias_valid_d;
            bias_out_q    <= bias_out_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            beats_left_q  <= beats_left_d;
            words_left_q  <= words_left_d;
            lane_q        <= lane_d;
            ack_timer_q   <= ack_timer_d;
            outstanding_q <= outstanding_d;
            occ_q         <= occ_d;
        end
    end

endmodule

// File: tb/tb_bias_stream_loader.sv
// Directed bench for bias_stream_loader: memory responder with configurable
// latency/stall, expected-beat scoreboard, reset and timeout scenarios.
module tb_bias_stream_loader;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [8:0]  num_channels = 9'd0;
    logic        busy, done, error, mem_req, load_bias, bias_valid;
    logic [31:0] mem_addr, bias_out;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        bias_loaded = 1'b0;

    always #5 clk = ~clk;

    bias_stream_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_channels (num_channels),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .load_bias    (load_bias),
        .bias_valid   (bias_valid),
        .bias_out     (bias_out),
        .bias_loaded  (bias_loaded)
    );

    typedef struct {
        logic [63:0] data;
        int          due;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] bias_tbl [128];
    logic [31:0] exp_q [$];
    pend_t       pend_q [$];
    logic [31:0] cur_base = 32'd0;
    int          lat_cfg = 2;
    int          gnt_idx = 0;
    int          out_cnt = 0;
    int          out_peak = 0;
    int          stall_at = -1;
    int          stall_left = 0;
    int          ncyc = 0;
    int          n_load = 0, n_done = 0, n_err = 0, n_req = 0;
    int          last_beat_cyc = 0, err_cyc = 0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and output monitor, evaluated away from the active edge
    always @(negedge clk) begin
        pend_t p;
        int    idx;
        ncyc++;
        if (!rst && prev_req && !prev_gnt) begin
            chk("req_held", {31'd0, mem_req}, 64'd1);
            chk("addr_held", mem_addr, prev_addr);
        end
        if (!rst && prev_req && prev_gnt) begin
            chk("read_addr", prev_addr, cur_base + 32'(8 * gnt_idx));
            idx    = int'((prev_addr - cur_base) >> 3);
            p.data = {bias_tbl[(2*idx+1) % 128], bias_tbl[(2*idx) % 128]};
            p.due  = ncyc + lat_cfg - 1;
            pend_q.push_back(p);
            gnt_idx++;
            out_cnt++;
            if (out_cnt > out_peak) out_peak = out_cnt;
            chk("outstanding_le_max", {63'd0, out_cnt <= MAXO}, 64'd1);
        end
        if (pend_q.size() != 0 && pend_q[0].due <= ncyc) begin
            p = pend_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = p.data;
            out_cnt--;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 64'd0;
        end
        if (!rst && mem_req && gnt_idx == stall_at && stall_left > 0) begin
            mem_gnt = 1'b0;
            stall_left--;
        end else begin
            mem_gnt = 1'b1;
        end
        prev_req  = rst ? 1'b0 : mem_req;
        prev_gnt  = mem_gnt;
        prev_addr = mem_addr;
        if (bias_valid) begin
            last_beat_cyc = ncyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", bias_out, 64'hDEAD_BEEF_0000_0000);
            end else begin
                chk("beat", bias_out, exp_q.pop_front());
            end
        end
        if (load_bias) n_load++;
        if (done) n_done++;
        if (error) begin
            n_err++;
            err_cyc = ncyc;
        end
        if (mem_req) n_req++;
    end

    task automatic clear_counts();
        n_load = 0; n_done = 0; n_err = 0; n_req = 0; out_peak = 0;
    endtask

    task automatic run_load(input logic [31:0] base, input int n, input int lat,
                            input bit ack, input bit poke);
        int k;
        cur_base = base;
        gnt_idx  = 0;
        lat_cfg  = lat;
        clear_counts();
        for (int i = 0; i < n; i++) exp_q.push_back(bias_tbl[i]);
        @(negedge clk);
        start = 1'b1; base_addr = base; num_channels = n[8:0];
        @(negedge clk);
        start = 1'b0; base_addr = 32'd0; num_channels = 9'd0;
        #1 chk("clear_pulse", {61'd0, load_bias, busy, mem_req}, 64'b110);
        @(negedge clk);
        #1 chk("clear_once", {63'd0, load_bias}, 64'd0);
        if (poke) begin
            start = 1'b1; base_addr = 32'h0000_8000; num_channels = 9'd7;
            @(negedge clk);
            start = 1'b0; base_addr = 32'd0; num_channels = 9'd0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk); #1; k++;
        end
        chk("beats_drained", exp_q.size(), 64'd0);
        if (ack) begin
            bias_loaded = 1'b1;
            @(negedge clk);
            #1 chk("done_pulse", {61'd0, done, error, busy}, 64'b100);
            bias_loaded = 1'b0;
            @(negedge clk);
            #1 chk("done_single", n_done, 64'd1);
        end else begin
            k = 0;
            while (n_err == 0 && k < 40) begin
                @(negedge clk); #1; k++;
            end
            chk("ack_timeout_seen", n_err, 64'd1);
            chk("ack_timeout_delay", err_cyc - last_beat_cyc, 64'd16);
            chk("timeout_no_done", n_done, 64'd0);
            chk("timeout_busy_low", {63'd0, busy}, 64'd0);
        end
        chk("load_bias_count", n_load, 64'd1);
        chk("read_count", gnt_idx, 64'((n + 1) / 2));
    endtask

    initial begin
        int k;
        // Reset state
        repeat (3) @(negedge clk);
        #1 chk("reset_ctrl", {58'd0, busy, done, error, mem_req, load_bias, bias_valid}, 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_bias", bias_out, 64'd0);
        rst = 1'b0;

        // 1: five biases, three words, latency 2
        for (int i = 0; i < 6; i++) bias_tbl[i] = 32'(i + 1);
        run_load(32'h0000_1000, 5, 2, 1'b1, 1'b0);

        // 2: second request stalled for 10 cycles
        for (int i = 0; i < 6; i++) bias_tbl[i] = 32'(i + 10);
        stall_at = 1; stall_left = 10;
        run_load(32'h0000_1000, 6, 3, 1'b1, 1'b0);
        chk("stall_consumed", stall_left, 64'd0);
        stall_at = -1;

        // 3: long latency, credit limit
        for (int i = 0; i < 64; i++) bias_tbl[i] = 32'(i * 3 - 100);
        run_load(32'h0000_4000, 64, 20, 1'b1, 1'b0);
        chk("peak_outstanding", out_peak, 64'd4);

        // 4: zero channels, then start while busy
        clear_counts();
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_1000; num_channels = 9'd0;
        @(negedge clk);
        start = 1'b0;
        #1 chk("zero_ch_error", {60'd0, error, load_bias, busy, mem_req}, 64'b1000);
        repeat (5) @(negedge clk);
        #1 chk("zero_ch_no_req", n_req, 64'd0);
        chk("zero_ch_no_load", n_load, 64'd0);
        for (int i = 0; i < 4; i++) bias_tbl[i] = 32'hA000_0000 + 32'(i);
        run_load(32'h0000_1000, 4, 2, 1'b1, 1'b1);

        // 5: no acknowledge
        for (int i = 0; i < 3; i++) bias_tbl[i] = 32'hFFFF_FFF0 + 32'(i);
        run_load(32'h0000_2000, 3, 2, 1'b0, 1'b0);

        // 6: reset with three reads outstanding, then a fresh load
        for (int i = 0; i < 64; i++) bias_tbl[i] = 32'h5500_0000 + 32'(i);
        cur_base = 32'h0000_1000; gnt_idx = 0; lat_cfg = 20;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_1000; num_channels = 9'd64;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (out_cnt != 3 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        chk("three_outstanding", out_cnt, 64'd3);
        rst = 1'b1;
        #1 chk("rst_mid_ctrl", {58'd0, busy, done, error, mem_req, load_bias, bias_valid}, 64'd0);
        chk("rst_mid_addr", mem_addr, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (30) @(negedge clk);
        #1 chk("late_rvalid_drained", pend_q.size(), 64'd0);
        chk("idle_after_rst", {63'd0, busy}, 64'd0);
        bias_tbl[0] = 32'd777;
        bias_tbl[1] = 32'hFFFF_FFFB;
        run_load(32'h0000_3000, 2, 2, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
